serial_feeder: RTL and testbench

SERIAL_FEEDER -- requirements
Module: serial_feeder

---
 rtl/serial_pkg.sv | 13 +
 rtl/flex_pts_sr.sv | 35 +++
 rtl/serial_feeder.sv | 133 +++++++++++++
 tb/tb_serial_feeder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial feeder and its sequence-detector bench.
// The PARITY state is only entered when SERIAL_FEEDER_PARITY_EN is defined.
package serial_pkg;

  localparam int unsigned DEFAULT_NUM_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register with synchronous load and shift enables.
// Vacated positions fill with 0, so a fully shifted word leaves the output low.
module flex_pts_sr
  import serial_pkg::*;
#(
  parameter int unsigned NUM_BITS  = DEFAULT_NUM_BITS,
  parameter int unsigned SHIFT_MSB = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_sr <= '0;
    end else if (load_enable) begin
      r_sr <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB != 0) begin
        r_sr <= {r_sr[NUM_BITS-2:0], 1'b0};
      end else begin
        r_sr <= {1'b0, r_sr[NUM_BITS-1:1]};
      end
    end
  end

  assign serial_out = (SHIFT_MSB != 0) ? r_sr[NUM_BITS-1] : r_sr[0];

endmodule

// File: rtl/serial_feeder.sv
// Word-to-bit serializer feeding a sequence detector; FSM and bit counter live here.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit after each word.
module serial_feeder
  import serial_pkg::*;
#(
  parameter int unsigned NUM_BITS  = DEFAULT_NUM_BITS,
  parameter int unsigned SHIFT_MSB = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_BITS-1:0] load_data,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                shift_enable,
  output logic                serial_out,
  output logic                serial_valid,
  output logic                busy
);

  localparam int unsigned       CNT_W    = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(NUM_BITS);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_valid;
  logic                w_last_bit;
  logic                w_final;
  logic                w_xfer;
  logic                w_sr_load;
  logic                w_sr_shift;
  logic [NUM_BITS-1:0] w_sr_data;

  assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST_IDX);

`ifdef SERIAL_FEEDER_PARITY_EN
  logic                r_parity;
  logic                w_par_load;
  logic [NUM_BITS-1:0] w_par_word;

  // The parity bit is loaded into the output position so serial_out stays a flop.
  assign w_final    = (r_state == PARITY);
  assign w_par_load = w_last_bit && shift_enable;
  assign w_par_word = (SHIFT_MSB != 0) ? {r_parity, {(NUM_BITS - 1){1'b0}}}
                                       : {{(NUM_BITS - 1){1'b0}}, r_parity};
  assign w_sr_load  = w_xfer || w_par_load;
  assign w_sr_data  = w_xfer ? load_data : w_par_word;
`else
  assign w_final    = w_last_bit;
  assign w_sr_load  = w_xfer;
  assign w_sr_data  = load_data;
`endif

  assign load_ready = (r_state == IDLE) || (w_final && shift_enable);
  assign w_xfer     = load_valid && load_ready;
  assign w_sr_shift = shift_enable && (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
      if (w_xfer) r_parity <= ^load_data;
`endif
      unique case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (shift_enable) begin
            if (r_cnt == LAST_IDX) begin
`ifdef SERIAL_FEEDER_PARITY_EN
              r_state <= PARITY;
              r_cnt   <= CNT_MAX;
`else
              r_cnt <= '0;
              if (!w_xfer) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
              end
`endif
            end else if (r_cnt < CNT_MAX) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
`ifdef SERIAL_FEEDER_PARITY_EN
        PARITY: begin
          if (shift_enable) begin
            r_cnt <= '0;
            if (w_xfer) begin
              r_state <= SHIFT;
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  flex_pts_sr #(
    .NUM_BITS (NUM_BITS),
    .SHIFT_MSB(SHIFT_MSB)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_enable (w_sr_load),
    .shift_enable(w_sr_shift),
    .parallel_in (w_sr_data),
    .serial_out  (serial_out)
  );

  assign serial_valid = r_valid;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_serial_feeder.sv
// Bench for serial_feeder: MSB-first and LSB-first instances share stimulus and are
// compared each cycle against a queue-of-pending-bits reference model.
module tb_serial_feeder;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       load_valid;
  logic       shift_enable;
  logic [7:0] load_data;
  logic       m_ready, m_out, m_valid, m_busy;
  logic       l_ready, l_out, l_valid, l_busy;

  always #5 clk = ~clk;

  serial_feeder #(.NUM_BITS(8), .SHIFT_MSB(1)) dut_m (
    .clk(clk), .n_rst(n_rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_ready), .shift_enable(shift_enable), .serial_out(m_out),
    .serial_valid(m_valid), .busy(m_busy)
  );

  serial_feeder #(.NUM_BITS(8), .SHIFT_MSB(0)) dut_l (
    .clk(clk), .n_rst(n_rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(l_ready), .shift_enable(shift_enable), .serial_out(l_out),
    .serial_valid(l_valid), .busy(l_busy)
  );

  // Reference model: bits still to be presented, head = bit on the line now.
  bit   q_m[$];
  bit   q_l[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic xfer;

`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int WORD_CYCLES = 9;
`else
  localparam int WORD_CYCLES = 8;
`endif

  // {serial_out, serial_valid, load_ready, busy}
  function automatic logic [3:0] model_exp(input bit lsb);
    int n;
    logic b;
    n = q_m.size();
    b = (n == 0) ? 1'b0 : (lsb ? q_l[0] : q_m[0]);
    return {b, n > 0, (n == 0) || (n == 1 && shift_enable), n > 0};
  endfunction

  task automatic fill(input logic [7:0] w);
    q_m.delete();
    q_l.delete();
    for (int i = 0; i < 8; i++) begin
      q_m.push_back(w[7-i]);
      q_l.push_back(w[i]);
    end
`ifdef SERIAL_FEEDER_PARITY_EN
    q_m.push_back(^w);
    q_l.push_back(^w);
`endif
  endtask

  task automatic tick();
    bit rdy;
    rdy  = (q_m.size() == 0) || (q_m.size() == 1 && shift_enable);
    xfer = n_rst && load_valid && rdy;
    if (!n_rst) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (shift_enable && q_m.size() > 0) begin
        void'(q_m.pop_front());
        void'(q_l.pop_front());
      end
      if (xfer) fill(load_data);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; load_valid = 1'b0; shift_enable = 1'b0; load_data = 8'h00;
    tick();
    tick();
    #1;
    checks++;
    if ({m_out, m_valid, m_ready, m_busy} !== model_exp(0)) begin
      errors++; $display("FAIL reset_m cyc=%0d got %b want %b", cyc,
                         {m_out, m_valid, m_ready, m_busy}, model_exp(0));
    end
    n_rst = 1'b1;
    #1;
    checks++;
    if ({l_out, l_valid, l_ready, l_busy} !== 4'b0010) begin
      errors++; $display("FAIL reset_release_l cyc=%0d got %b want 0010", cyc,
                         {l_out, l_valid, l_ready, l_busy});
    end
    tick();
  endtask

  task automatic test_msb_first();
    int nb = 0, det = 0;
    logic [7:0] rec = '0;
    logic [3:0] win = '0;
    load_data = 8'hD0; load_valid = 1'b1; shift_enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if ({m_out, m_valid, m_ready, m_busy} !== model_exp(0)) begin
        errors++; $display("FAIL msb_m cyc=%0d got %b want %b", cyc,
                           {m_out, m_valid, m_ready, m_busy}, model_exp(0));
      end
      checks++;
      if ({l_out, l_valid, l_ready, l_busy} !== model_exp(1)) begin
        errors++; $display("FAIL msb_l cyc=%0d got %b want %b", cyc,
                           {l_out, l_valid, l_ready, l_busy}, model_exp(1));
      end
      if (m_valid) begin
        if (nb < 8) rec[7-nb] = m_out;
        win = {win[2:0], m_out};
        nb++;
        if (nb >= 4 && win == 4'b1101) det++;
      end
      tick();
      if (xfer) load_valid = 1'b0;
    end
    checks++;
    if (rec !== 8'b1101_0000) begin
      errors++; $display("FAIL msb_bits got %b want 11010000", rec);
    end
    checks++;
    if (det != 1) begin
      errors++; $display("FAIL msb_detect got %0d want 1", det);
    end
  endtask

  task automatic test_lsb_first();
    int nb = 0, det = 0;
    logic [7:0] rec = '0;
    logic [3:0] win = '0;
    load_data = 8'h0B; load_valid = 1'b1; shift_enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if ({l_out, l_valid, l_ready, l_busy} !== model_exp(1)) begin
        errors++; $display("FAIL lsb_l cyc=%0d got %b want %b", cyc,
                           {l_out, l_valid, l_ready, l_busy}, model_exp(1));
      end
      if (l_valid) begin
        if (nb < 8) rec[7-nb] = l_out;
        win = {win[2:0], l_out};
        nb++;
        if (nb >= 4 && win == 4'b1101) det++;
      end
      tick();
      if (xfer) load_valid = 1'b0;
    end
    checks++;
    if (rec !== 8'b1101_0000 || det != 1) begin
      errors++; $display("FAIL lsb_bits got %b det %0d want 11010000 det 1", rec, det);
    end
  endtask

  task automatic test_word_length(input logic [7:0] w);
    int nb = 0;
    logic last = 1'b0;
    load_data = w; load_valid = 1'b1; shift_enable = 1'b1;
    for (int c = 0; c < 13; c++) begin
      #1;
      checks++;
      if ({m_out, m_valid, m_ready, m_busy} !== model_exp(0)) begin
        errors++; $display("FAIL length_m cyc=%0d got %b want %b", cyc,
                           {m_out, m_valid, m_ready, m_busy}, model_exp(0));
      end
      if (m_valid) begin
        nb++;
        last = m_out;
      end
      tick();
      if (xfer) load_valid = 1'b0;
    end
    checks++;
    if (nb != WORD_CYCLES) begin
      errors++; $display("FAIL length_cycles word %h got %0d want %0d", w, nb, WORD_CYCLES);
    end
`ifdef SERIAL_FEEDER_PARITY_EN
    checks++;
    if (last !== ^w) begin
      errors++; $display("FAIL parity_bit word %h got %b want %b", w, last, ^w);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int nx = 0, run = 0, best = 0;
    load_data = 8'hAA; load_valid = 1'b1; shift_enable = 1'b1;
    for (int c = 0; c < 24; c++) begin
      #1;
      checks++;
      if ({m_out, m_valid, m_ready, m_busy} !== model_exp(0)) begin
        errors++; $display("FAIL b2b_m cyc=%0d got %b want %b", cyc,
                           {m_out, m_valid, m_ready, m_busy}, model_exp(0));
      end
      run  = m_valid ? run + 1 : 0;
      best = (run > best) ? run : best;
      tick();
      if (xfer) begin
        nx++;
        if (nx == 1) load_data = 8'h55;
        else load_valid = 1'b0;
      end
    end
    checks++;
    if (best != 2 * WORD_CYCLES) begin
      errors++; $display("FAIL b2b_run got %0d want %0d", best, 2 * WORD_CYCLES);
    end
  endtask

  task automatic test_stall();
    load_data = 8'hF0; load_valid = 1'b1; shift_enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      shift_enable = !(c >= 4 && c < 7);
      #1;
      checks++;
      if ({m_out, m_valid, m_ready, m_busy} !== model_exp(0)) begin
        errors++; $display("FAIL stall_m cyc=%0d got %b want %b", cyc,
                           {m_out, m_valid, m_ready, m_busy}, model_exp(0));
      end
      if (c >= 4 && c < 7) begin
        checks++;
        if (m_out !== 1'b1) begin
          errors++; $display("FAIL stall_hold cyc=%0d got %b want 1", cyc, m_out);
        end
      end
      tick();
      if (xfer) load_valid = 1'b0;
    end
    shift_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    load_data = 8'h5A; load_valid = 1'b1; shift_enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      n_rst = (c != 5);
      if (c == 9) begin
        load_data = 8'hC3; load_valid = 1'b1;
      end
      #1;
      if (c == 6) begin
        checks++;
        if ({m_valid, m_out, m_busy, m_ready} !== 4'b0001) begin
          errors++; $display("FAIL reset_mid cyc=%0d got %b want 0001", cyc,
                             {m_valid, m_out, m_busy, m_ready});
        end
      end
      checks++;
      if ({l_out, l_valid, l_ready, l_busy} !== model_exp(1)) begin
        errors++; $display("FAIL reset_mid_l cyc=%0d got %b want %b", cyc,
                           {l_out, l_valid, l_ready, l_busy}, model_exp(1));
      end
      tick();
      if (xfer) load_valid = 1'b0;
    end
    n_rst = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      n_rst        = ($urandom_range(0, 60) != 0);
      load_valid   = $urandom_range(0, 1) != 0;
      shift_enable = ($urandom_range(0, 3) != 0);
      load_data    = 8'($urandom);
      #1;
      checks++;
      if ({m_out, m_valid, m_ready, m_busy} !== model_exp(0)) begin
        errors++; $display("FAIL random_m cyc=%0d got %b want %b", cyc,
                           {m_out, m_valid, m_ready, m_busy}, model_exp(0));
      end
      checks++;
      if ({l_out, l_valid, l_ready, l_busy} !== model_exp(1)) begin
        errors++; $display("FAIL random_l cyc=%0d got %b want %b", cyc,
                           {l_out, l_valid, l_ready, l_busy}, model_exp(1));
      end
      tick();
    end
    n_rst = 1'b1; load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_word_length(8'hB3);
    test_word_length(8'h03);
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
